// File: rtl/cache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_pkg : shared state encoding, geometry constants and byte-merge helper
// Revision  : 1.0
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int LINE_OFFSET_BITS = 4;
  localparam int WORD_SEL_BITS    = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_WB_REQ  = 3'd2,
    ST_WB_DATA = 3'd3,
    ST_RF_REQ  = 3'd4,
    ST_RF_WAIT = 3'd5
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm_cache_array : flop-based valid/dirty/tag/data store, async read by index
// Revision       : 1.0
// ---------------------------------------------------------------------------
module dm_cache_array
  import cache_pkg::*;
#(
  parameter int LINES     = 64,
  parameter int IDX_BITS  = 6,
  parameter int TAG_BITS  = 22,
  parameter int LINE_BITS = 128,
  parameter int CPU_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IDX_BITS-1:0]      index,
  output logic                     valid,
  output logic                     dirty,
  output logic [TAG_BITS-1:0]      tag,
  output logic [LINE_BITS-1:0]     line,
  input  logic                     line_we,
  input  logic [LINE_BITS-1:0]     line_data,
  input  logic [TAG_BITS-1:0]      line_tag,
  input  logic                     word_we,
  input  logic [WORD_SEL_BITS-1:0] word_sel,
  input  logic [CPU_WIDTH-1:0]     word_data,
  input  logic [CPU_WIDTH/8-1:0]   word_mask
);

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign line  = data_q[index];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[index] <= line_data;
      tag_q[index]  <= line_tag;
    end else if (word_we) begin
      data_q[index][word_sel*CPU_WIDTH +: CPU_WIDTH] <=
        merge_bytes(data_q[index][word_sel*CPU_WIDTH +: CPU_WIDTH], word_data, word_mask);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dm_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm_cache : direct-mapped write-back/write-allocate cache, 128-bit mem port
// Revision : 1.0
// ---------------------------------------------------------------------------
module dm_cache
  import cache_pkg::*;
#(
  parameter int LINES         = 64,
  parameter int CPU_WIDTH     = 32,
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_ADDR_BITS = 28
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req_valid,
  output logic                     cpu_req_ready,
  input  logic [31:0]              cpu_req_addr,
  input  logic [CPU_WIDTH-1:0]     cpu_req_data,
  input  logic [3:0]               cpu_req_write,
  output logic                     cpu_resp_valid,
  output logic [CPU_WIDTH-1:0]     cpu_resp_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [15:0]              mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = 32 - LINE_OFFSET_BITS - IDX_BITS;
  localparam int LSB      = LINE_OFFSET_BITS - WORD_SEL_BITS;

  state_t state, state_next;

  logic [31:LSB]              req_addr;
  logic [CPU_WIDTH-1:0]       req_data;
  logic [3:0]                 req_mask;
  logic [IDX_BITS-1:0]        req_index;
  logic [TAG_BITS-1:0]        req_tag;
  logic [WORD_SEL_BITS-1:0]   req_word;

  logic                       arr_valid;
  logic                       arr_dirty;
  logic [TAG_BITS-1:0]        arr_tag;
  logic [MEM_DATA_BITS-1:0]   arr_line;
  logic                       line_we;
  logic                       word_we;
  logic                       hit;
  logic                       is_write;
  logic                       unused_addr_bits;

  // Sub-word byte offset never affects a word access.
  assign unused_addr_bits = ^cpu_req_addr[LSB-1:0];

  assign req_word  = req_addr[LINE_OFFSET_BITS-1 -: WORD_SEL_BITS];
  assign req_index = req_addr[LINE_OFFSET_BITS +: IDX_BITS];
  assign req_tag   = req_addr[31 -: TAG_BITS];
  assign hit       = arr_valid && (arr_tag == req_tag);
  assign is_write  = |req_mask;

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cpu_req_valid) begin
      req_addr <= cpu_req_addr[31:LSB];
      req_data <= cpu_req_data;
      req_mask <= cpu_req_write;
    end
  end

  dm_cache_array #(
    .LINES     (LINES),
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS),
    .LINE_BITS (MEM_DATA_BITS),
    .CPU_WIDTH (CPU_WIDTH)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (req_index),
    .valid     (arr_valid),
    .dirty     (arr_dirty),
    .tag       (arr_tag),
    .line      (arr_line),
    .line_we   (line_we),
    .line_data (mem_resp_data),
    .line_tag  (req_tag),
    .word_we   (word_we),
    .word_sel  (req_word),
    .word_data (req_data),
    .word_mask (req_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (cpu_req_valid) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)                         state_next = ST_IDLE;
        else if (arr_valid && arr_dirty) state_next = ST_WB_REQ;
        else                             state_next = ST_RF_REQ;
      end
      ST_WB_REQ:  if (mem_req_ready)      state_next = ST_WB_DATA;
      ST_WB_DATA: if (mem_req_data_ready) state_next = ST_RF_REQ;
      ST_RF_REQ:  if (mem_req_ready)      state_next = ST_RF_WAIT;
      ST_RF_WAIT: if (mem_resp_valid)     state_next = ST_LOOKUP;
      default:                            state_next = ST_IDLE;
    endcase
  end

  // Memory-side outputs depend only on state, latched request and the
  // indexed line, so they hold steady while a command waits for ready.
  always_comb begin
    cpu_req_ready      = 1'b0;
    cpu_resp_valid     = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = MEM_ADDR_BITS'({req_tag, req_index});
    mem_req_data_valid = 1'b0;
    line_we            = 1'b0;
    word_we            = 1'b0;
    case (state)
      ST_IDLE:    cpu_req_ready = 1'b1;
      ST_LOOKUP: begin
        cpu_resp_valid = hit && !is_write;
        word_we        = hit && is_write && !reset;
      end
      ST_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = MEM_ADDR_BITS'({arr_tag, req_index});
      end
      ST_WB_DATA: mem_req_data_valid = 1'b1;
      ST_RF_REQ:  mem_req_valid      = 1'b1;
      ST_RF_WAIT: line_we            = mem_resp_valid && !reset;
      default: ;
    endcase
  end

  assign cpu_resp_data     = arr_line[req_word*CPU_WIDTH +: CPU_WIDTH];
  assign mem_req_data_bits = arr_line;
  assign mem_req_data_mask = 16'hFFFF;

endmodule
`default_nettype wire

// File: tb/tb_dm_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dm_cache : vector table plus directed backpressure and reset-abort runs
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_dm_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_data;
  logic [3:0]   cpu_req_write;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  dm_cache #(.LINES(64), .CPU_WIDTH(32), .MEM_DATA_BITS(128), .MEM_ADDR_BITS(28)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_write(cpu_req_write),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic mem_ready_en      = 1'b1;
  logic mem_data_ready_en = 1'b1;
  assign mem_req_ready      = mem_ready_en;
  assign mem_req_data_ready = mem_data_ready_en;

  logic [127:0] mem [logic [27:0]];
  int           rd_cmds = 0, wb_cmds = 0, wb_beats = 0, rd_wait = 0, resp_delay = 0;
  logic [27:0]  last_rf_addr = '0, last_wb_addr = '0;
  logic [127:0] last_wb_line = '0;
  logic [15:0]  last_wb_mask = '0;

  function automatic logic [127:0] mem_init(input logic [27:0] b);
    if (b == 28'h4) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    return {b[23:0], 8'h03, b[23:0], 8'h02, b[23:0], 8'h01, b[23:0], 8'h00};
  endfunction

  function automatic logic [127:0] mem_read(input logic [27:0] b);
    if (mem.exists(b)) return mem[b];
    return mem_init(b);
  endfunction

  // Memory model: samples just after the falling edge, drives for the next rise.
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk); #1;
      mem_resp_valid = 1'b0;
      if (reset) begin
        rd_wait = 0;
        continue;
      end
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_read(last_rf_addr);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_rw) begin
          wb_cmds++;
          last_wb_addr = mem_req_addr;
        end else begin
          rd_cmds++;
          last_rf_addr = mem_req_addr;
          rd_wait      = resp_delay + 1;
        end
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
        wb_beats++;
        last_wb_line      = mem_req_data_bits;
        last_wb_mask      = mem_req_data_mask;
        mem[last_wb_addr] = mem_req_data_bits;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, required completion", n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("req_ready_timeout", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    cpu_req_data  = d;
    cpu_req_write = m;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_write = 4'h0;
  endtask

  task automatic wait_done(input logic [3:0] m, output logic [31:0] rdata, output int lat);
    int n = 0;
    while (n < 200 && !((m == 4'h0) ? cpu_resp_valid : cpu_req_ready)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", (m == 4'h0) ? cpu_resp_valid : cpu_req_ready, 1);
    rdata = cpu_resp_data;
    lat   = n + 1;
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [3:0]   mask;
    logic [31:0]  exp_rdata;
    int           exp_rd;
    int           exp_wb;
    logic [27:0]  exp_rf_addr;
    logic [27:0]  exp_wb_addr;
    logic [127:0] exp_wb_line;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                              input logic [31:0] e, input int rd, input int wb,
                              input logic [27:0] rfa, input logic [27:0] wba,
                              input logic [127:0] line);
    vec_t v;
    v.addr = a; v.data = d; v.mask = m; v.exp_rdata = e; v.exp_rd = rd; v.exp_wb = wb;
    v.exp_rf_addr = rfa; v.exp_wb_addr = wba; v.exp_wb_line = line;
    return v;
  endfunction

  initial begin
    vec_t        vecs[18];
    logic [31:0] rdata;
    int          lat, rd0, wb0, n;

    vecs[0]  = mk(32'h040, 0, 4'h0, 32'hAAAAAAAA, 1, 0, 28'h04, 0, 0);
    vecs[1]  = mk(32'h044, 0, 4'h0, 32'hBBBBBBBB, 0, 0, 0, 0, 0);
    vecs[2]  = mk(32'h048, 32'h12345678, 4'h3, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(32'h048, 0, 4'h0, 32'hCCCC5678, 0, 0, 0, 0, 0);
    vecs[4]  = mk(32'h04C, 0, 4'h0, 32'hDDDDDDDD, 0, 0, 0, 0, 0);
    vecs[5]  = mk(32'h04F, 0, 4'h0, 32'hDDDDDDDD, 0, 0, 0, 0, 0);
    vecs[6]  = mk(32'h440, 0, 4'h0, 32'h00004400, 1, 1, 28'h44, 28'h04,
                  128'hDDDDDDDD_CCCC5678_BBBBBBBB_AAAAAAAA);
    vecs[7]  = mk(32'h840, 0, 4'h0, 32'h00008400, 1, 0, 28'h84, 0, 0);
    vecs[8]  = mk(32'h048, 0, 4'h0, 32'hCCCC5678, 1, 0, 28'h04, 0, 0);
    vecs[9]  = mk(32'h3F0, 0, 4'h0, 32'h00003F00, 1, 0, 28'h3F, 0, 0);
    vecs[10] = mk(32'h400, 0, 4'h0, 32'h00004000, 1, 0, 28'h40, 0, 0);
    vecs[11] = mk(32'h3FC, 32'hAABBCCDD, 4'h8, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(32'h3FC, 0, 4'h0, 32'hAA003F03, 0, 0, 0, 0, 0);
    vecs[13] = mk(32'h3F8, 32'h11223344, 4'h5, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(32'h3F8, 0, 4'h0, 32'h00223F44, 0, 0, 0, 0, 0);
    vecs[15] = mk(32'h500, 32'hCAFEF00D, 4'hF, 0, 1, 0, 28'h50, 0, 0);
    vecs[16] = mk(32'h500, 0, 4'h0, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    vecs[17] = mk(32'h7F0, 0, 4'h0, 32'h00007F00, 1, 1, 28'h7F, 28'h3F,
                  128'hAA003F03_00223F44_00003F01_00003F00);

    cpu_req_valid = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_data  = '0;
    cpu_req_write = 4'h0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", cpu_req_ready, 1);
    check("rst_resp_valid", cpu_resp_valid, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_data_valid", mem_req_data_valid, 0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      rd0 = rd_cmds;
      wb0 = wb_beats;
      n   = wb_cmds;
      start_req(vecs[i].addr, vecs[i].data, vecs[i].mask);
      wait_done(vecs[i].mask, rdata, lat);
      if (vecs[i].mask == 4'h0) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_refills", i), rd_cmds - rd0, vecs[i].exp_rd);
      check($sformatf("v%0d_wb_beats", i), wb_beats - wb0, vecs[i].exp_wb);
      check($sformatf("v%0d_wb_cmds", i), wb_cmds - n, vecs[i].exp_wb);
      if (vecs[i].exp_rd > 0) check($sformatf("v%0d_rf_addr", i), last_rf_addr, vecs[i].exp_rf_addr);
      if (vecs[i].exp_wb > 0) begin
        check($sformatf("v%0d_wb_addr", i), last_wb_addr, vecs[i].exp_wb_addr);
        check($sformatf("v%0d_wb_line", i), last_wb_line, vecs[i].exp_wb_line);
        check($sformatf("v%0d_wb_mask", i), last_wb_mask, 16'hFFFF);
      end
      if (vecs[i].exp_rd == 0 && vecs[i].mask == 4'h0) check($sformatf("v%0d_hit_latency", i), lat, 1);
    end

    // Refill command held off for ten cycles.
    mem_ready_en = 1'b0;
    rd0 = rd_cmds;
    start_req(32'h600, 0, 4'h0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp%0d_valid", i), mem_req_valid, 1);
      check($sformatf("bp%0d_addr", i), mem_req_addr, 28'h60);
      check($sformatf("bp%0d_rw", i), mem_req_rw, 0);
      check($sformatf("bp%0d_cpu_ready", i), cpu_req_ready, 0);
      @(negedge clk);
    end
    mem_ready_en = 1'b1;
    wait_done(4'h0, rdata, lat);
    check("bp_rdata", rdata, 32'h00006000);
    check("bp_refills", rd_cmds - rd0, 1);

    // Dirty victim with write-data channel held off.
    start_req(32'h600, 32'h600D600D, 4'hF);
    wait_done(4'hF, rdata, lat);
    mem_data_ready_en = 1'b0;
    wb0 = wb_beats;
    start_req(32'hA00, 0, 4'h0);
    n = 0;
    while (!mem_req_data_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wbh_reached", mem_req_data_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wbh%0d_valid", i), mem_req_data_valid, 1);
      check($sformatf("wbh%0d_bits", i), mem_req_data_bits,
            128'h00006003_00006002_00006001_600D600D);
      check($sformatf("wbh%0d_mask", i), mem_req_data_mask, 16'hFFFF);
      check($sformatf("wbh%0d_cpu_ready", i), cpu_req_ready, 0);
      @(negedge clk);
    end
    mem_data_ready_en = 1'b1;
    wait_done(4'h0, rdata, lat);
    check("wbh_rdata", rdata, 32'h0000A000);
    check("wbh_beats", wb_beats - wb0, 1);
    check("wbh_wb_addr", last_wb_addr, 28'h60);

    // Reset lands while the refill is outstanding.
    resp_delay = 5;
    start_req(32'h700, 0, 4'h0);
    n = 0;
    while (rd_wait == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_rf_wait", rd_wait > 0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_req_ready", cpu_req_ready, 1);
    check("abort_resp_valid", cpu_resp_valid, 0);
    check("abort_mem_req_valid", mem_req_valid, 0);
    check("abort_mem_data_valid", mem_req_data_valid, 0);
    @(negedge clk);
    reset      = 1'b0;
    resp_delay = 0;
    rd0 = rd_cmds;
    start_req(32'h700, 0, 4'h0);
    wait_done(4'h0, rdata, lat);
    check("abort_retry_rdata", rdata, 32'h00007000);
    check("abort_retry_refills", rd_cmds - rd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
